// File: rtl/sprite_dma_pkg.sv
// Shared sprite definitions: table geometry, CPU register map, control bits,
// DMA state encoding and the per-entry attribute layout used by the sprite engine.
package sprite_dma_pkg;

  localparam int unsigned SPR_COUNT_DFLT      = 32;
  localparam int unsigned SPR_ITEM_BYTES_DFLT = 4;

  localparam logic [1:0] REG_SRC_HI = 2'd0;
  localparam logic [1:0] REG_SRC_LO = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned CTRL_ARM_BIT  = 0;
  localparam int unsigned CTRL_AUTO_BIT = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic        enable;
    logic [11:0] y;
    logic [5:0]  image;
    logic [9:0]  x;
  } sprite_attr_t;

  // Bytes b0..b3 of one entry packed as {b0, b1, b2, b3}.
  function automatic sprite_attr_t unpack_sprite(input logic [31:0] b);
    sprite_attr_t s;
    s.enable = b[31];
    s.y      = {b[27:24], b[23:16]};
    s.image  = b[15:10];
    s.x      = {b[9:8], b[7:0]};
    return s;
  endfunction

endpackage

// File: rtl/sprite_dma.sv
// Sprite attribute DMA: on vblank, requests the CPU bus and copies the sprite
// table from main memory into sprite attribute RAM at two cycles per byte.
module sprite_dma
  import sprite_dma_pkg::*;
#(
  parameter int unsigned SPR_COUNT      = SPR_COUNT_DFLT,
  parameter int unsigned SPR_ITEM_BYTES = SPR_ITEM_BYTES_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_reg,
  input  logic [7:0]  cpu_data,
  output logic        busreq,
  input  logic        busack,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic [6:0]  spriteram_wr_addr,
  output logic        spriteram_wr,
  output logic [7:0]  spriteram_data_in,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned TABLE_BYTES = SPR_COUNT * SPR_ITEM_BYTES;
  localparam logic [7:0]  LAST_IDX    = 8'(TABLE_BYTES - 1);

  logic [2:0]  state_q,    state_d;
  logic [15:0] src_base_q, src_base_d;
  logic [15:0] src_addr_q, src_addr_d;
  logic [7:0]  index_q,    index_d;
  logic        auto_q,     auto_d;
  logic        overrun_q,  overrun_d;
  logic        wr_q,       wr_d;
  logic [6:0]  wr_addr_q,  wr_addr_d;
  logic [7:0]  wr_data_q,  wr_data_d;
  logic        vblank_q;

  logic xfer_active;
  logic vb_rise;
  logic vb_fall;
  logic ctrl_wr;

  assign xfer_active = (state_q == ST_REQ) || (state_q == ST_READ) || (state_q == ST_WRITE);
  assign vb_rise     = vblank & ~vblank_q;
  assign vb_fall     = ~vblank & vblank_q;
  assign ctrl_wr     = cpu_wr && (cpu_reg == REG_CTRL);

  always_comb begin
    state_d    = state_q;
    src_base_d = src_base_q;
    src_addr_d = src_addr_q;
    index_d    = index_q;
    auto_d     = auto_q;
    overrun_d  = overrun_q;
    wr_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (cpu_wr && !xfer_active) begin
      if (cpu_reg == REG_SRC_HI) src_base_d[15:8] = cpu_data;
      if (cpu_reg == REG_SRC_LO) src_base_d[7:0]  = cpu_data;
    end

    // A vblank that ends mid-copy outranks a simultaneous clearing write.
    if (ctrl_wr) begin
      auto_d    = cpu_data[CTRL_AUTO_BIT];
      overrun_d = 1'b0;
    end
    if (xfer_active && vb_fall) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && cpu_data[CTRL_ARM_BIT]) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (ctrl_wr && !cpu_data[CTRL_ARM_BIT]) state_d = ST_IDLE;
        else if (vb_rise)                       state_d = ST_REQ;
      end
      ST_REQ: begin
        if (busack) begin
          index_d    = '0;
          src_addr_d = src_base_q;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (busack) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Losing the bus here drops the byte; READ re-fetches it from the same address.
        if (!busack) begin
          state_d = ST_READ;
        end else begin
          wr_d       = 1'b1;
          wr_addr_d  = index_q[6:0];
          wr_data_d  = src_data;
          index_d    = index_q + 8'd1;
          src_addr_d = src_addr_q + 16'd1;
          state_d    = (index_q == LAST_IDX) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        state_d = auto_q ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      src_base_q <= '0;
      src_addr_q <= '0;
      index_q    <= '0;
      auto_q     <= 1'b0;
      overrun_q  <= 1'b0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      vblank_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_base_q <= src_base_d;
      src_addr_q <= src_addr_d;
      index_q    <= index_d;
      auto_q     <= auto_d;
      overrun_q  <= overrun_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      vblank_q   <= vblank;
    end
  end

  assign busreq            = xfer_active;
  assign busy              = xfer_active;
  assign overrun           = overrun_q;
  assign src_addr          = src_addr_q;
  assign spriteram_wr      = wr_q;
  assign spriteram_wr_addr = wr_addr_q;
  assign spriteram_data_in = wr_data_q;

endmodule
